// File: rtl/ppm_pkg.sv
// Shared PPM definitions: decoder states, default timing limits and channel counts.
// The timing defaults are common to the coder and decoder sides.
package ppm_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SYNC  = 2'd1,
    FRAME = 2'd2
  } state_e;

  localparam int PPM_SYNC_US = 3000;
  localparam int PPM_MIN_US  = 500;
  localparam int PPM_MAX_US  = 2500;

  localparam int PPM_CH4 = 4;
  localparam int PPM_CH8 = 8;

endpackage

// File: rtl/ppm_edge_sync.sv
// Two-flop synchroniser, polarity normalisation and registered leading-edge detect.
// Sync flops reset to the idle pad level so no edge is seen coming out of reset.
module ppm_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic inv,
  output logic rise
);

  logic s1;
  logic s2;
  logic norm;
  logic norm_q;

  assign norm = s2 ^ inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= inv;
      s2     <= inv;
      norm_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      norm_q <= norm;
      rise   <= norm & ~norm_q;
    end
  end

endmodule

// File: rtl/ppm_decoder.sv
// PPM receiver: measures leading-edge-to-leading-edge intervals in microseconds
// and emits per-channel samples, a frame strobe, lock status and framing errors.
//
// state | meaning
// HUNT  | waiting for a gap of SYNC_US with no edge; edges only restart the timer
// SYNC  | gap seen; next edge starts a frame
// FRAME | measuring channel intervals; a SYNC_US gap closes the frame
module ppm_decoder
  import ppm_pkg::*;
#(
  parameter int CLK_HZ  = 12000000,
  parameter int SYNC_US = PPM_SYNC_US,
  parameter int MIN_US  = PPM_MIN_US,
  parameter int MAX_US  = PPM_MAX_US,
  parameter int W       = 12
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_n,
  input  logic         ppm_in,
  input  logic         ppm_inv,
  input  logic         ch8,
  output logic         ch_valid,
  output logic [2:0]   ch_idx,
  output logic [W-1:0] ch_width,
  output logic         frame_valid,
  output logic         locked,
  output logic         err
);

  localparam int DIV = CLK_HZ / 1000000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);
  localparam logic [W-1:0]  T_SAT   = '1;
  localparam logic [W-1:0]  SYNC_T  = W'(SYNC_US);
  localparam logic [W-1:0]  MIN_T   = W'(MIN_US);
  localparam logic [W-1:0]  MAX_T   = W'(MAX_US);
  localparam logic [3:0]    N4      = 4'(PPM_CH4);
  localparam logic [3:0]    N8      = 4'(PPM_CH8);

  logic          edge_det;
  logic [PW-1:0] prescale;
  logic [W-1:0]  timer;
  logic          tick;
  logic [W-1:0]  t_now;
  state_e        state;
  logic [3:0]    count;
  logic          n8;
  logic [3:0]    n_ch;

  ppm_edge_sync u_edge_sync (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .raw   (ppm_in),
    .inv   (ppm_inv),
    .rise  (edge_det)
  );

  assign tick = (prescale == PS_LAST);
  // Interval including the microsecond that completes in this cycle, so an
  // edge exactly k us after the previous one measures k.
  assign t_now = (tick && timer != T_SAT) ? timer + W'(1) : timer;
  assign n_ch  = n8 ? N8 : N4;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      prescale <= '0;
      timer    <= '0;
    end else if (edge_det) begin
      prescale <= '0;
      timer    <= '0;
    end else begin
      prescale <= tick ? '0 : prescale + PW'(1);
      timer    <= t_now;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state       <= HUNT;
      count       <= '0;
      n8          <= 1'b0;
      ch_valid    <= 1'b0;
      ch_idx      <= '0;
      ch_width    <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
    end else begin
      ch_valid    <= 1'b0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      case (state)
        HUNT: begin
          if (!edge_det && timer == SYNC_T) state <= SYNC;
        end
        SYNC: begin
          if (edge_det) begin
            count <= '0;
            n8    <= ch8;
            state <= FRAME;
          end
        end
        FRAME: begin
          // An edge wins over a sync timeout landing in the same cycle.
          if (edge_det) begin
            if (count == n_ch || t_now < MIN_T || t_now > MAX_T) begin
              err    <= 1'b1;
              locked <= 1'b0;
              state  <= HUNT;
            end else begin
              ch_valid <= 1'b1;
              ch_idx   <= count[2:0];
              ch_width <= t_now;
              count    <= count + 4'd1;
            end
          end else if (timer == SYNC_T) begin
            if (count == n_ch) begin
              frame_valid <= 1'b1;
              locked      <= 1'b1;
            end else begin
              err    <= 1'b1;
              locked <= 1'b0;
            end
            state <= SYNC;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_ppm_decoder.sv
// Self-checking bench for ppm_decoder, run with a 1 MHz clock so one cycle is one us.
// Expected samples and frame/error events come from an interval-list model of the framing rules.
`timescale 1ns/1ps
module tb_ppm_decoder;

  localparam int SYNC   = 3000;
  localparam int MIN    = 500;
  localparam int MAX    = 2500;
  localparam int GAP    = 3100;
  localparam int FV_LAT = SYNC + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ppm_in = 1'b0;
  logic        ppm_inv = 1'b0;
  logic        ch8 = 1'b0;
  logic        ch_valid;
  logic [2:0]  ch_idx;
  logic [11:0] ch_width;
  logic        frame_valid;
  logic        locked;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ivs[16];
  int n_iv;
  int edge_cyc[17];
  int got_idx[$], got_w[$], got_cyc[$], fv_cyc[$], err_cyc[$];
  int exp_idx[$], exp_w[$];
  int exp_fv, exp_err;

  ppm_decoder #(.CLK_HZ(1000000)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (rst_n),
    .ppm_in      (ppm_in),
    .ppm_inv     (ppm_inv),
    .ch8         (ch8),
    .ch_valid    (ch_valid),
    .ch_idx      (ch_idx),
    .ch_width    (ch_width),
    .frame_valid (frame_valid),
    .locked      (locked),
    .err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ch_valid) begin
        got_idx.push_back(int'(ch_idx));
        got_w.push_back(int'(ch_width));
        got_cyc.push_back(cyc);
      end
      if (frame_valid) fv_cyc.push_back(cyc);
      if (err) err_cyc.push_back(cyc);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_idx.delete(); got_w.delete(); got_cyc.delete();
    fv_cyc.delete(); err_cyc.delete();
  endtask

  // Framing rules applied to the list of edge-to-edge intervals.
  task automatic model(input bit n8sel, input bit synced, input int gap);
    int n, cnt;
    bit live;
    n = n8sel ? 8 : 4;
    cnt = 0;
    live = synced;
    exp_idx.delete(); exp_w.delete();
    exp_fv = 0; exp_err = 0;
    for (int i = 0; i < n_iv; i++) begin
      if (live) begin
        if (ivs[i] < MIN || ivs[i] > MAX || cnt == n) begin
          exp_err++;
          live = 0;
        end else begin
          exp_idx.push_back(cnt);
          exp_w.push_back(ivs[i]);
          cnt++;
        end
      end
    end
    if (live && gap >= SYNC) begin
      if (cnt == n) exp_fv++;
      else exp_err++;
    end
  endtask

  // n_edges leading edges; edge i is followed by ivs[i] us, the last one by tail us.
  task automatic send_edges(input int n_edges, input int tail);
    int pw, dur;
    for (int i = 0; i < n_edges; i++) begin
      pw = int'($urandom_range(40, 150));
      dur = (i < n_edges - 1) ? ivs[i] : tail;
      edge_cyc[i] = cyc;
      ppm_in = ~ppm_inv;
      wait_cyc(pw);
      ppm_in = ppm_inv;
      wait_cyc(dur - pw);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ppm_inv = 1'b0; ppm_in = 1'b0; ch8 = 1'b0;
    #23;
    checks++;
    if ({ch_valid, ch_idx, ch_width, frame_valid, locked, err} !== 19'd0)
      begin errors++; $display("FAIL reset_outputs got=%b want=0", {ch_valid, ch_idx, ch_width, frame_valid, locked, err}); end
    @(posedge clk); #1 rst_n = 1'b1;
    clear_logs();
    wait_cyc(GAP);
    checks++;
    if (got_w.size() + fv_cyc.size() + err_cyc.size() != 0)
      begin errors++; $display("FAIL idle_after_reset events=%0d want=0", got_w.size() + fv_cyc.size() + err_cyc.size()); end
  endtask

  task automatic test_basic(input string tag);
    ch8 = 1'b0;
    n_iv = 4; ivs[0] = 1000; ivs[1] = 1500; ivs[2] = 2000; ivs[3] = 1200;
    clear_logs(); model(0, 1, GAP);
    send_edges(n_iv + 1, GAP);
    checks++;
    if (got_w.size() != exp_w.size())
      begin errors++; $display("FAIL %s sample_count got=%0d want=%0d", tag, got_w.size(), exp_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_idx[i] != exp_idx[i] || got_w[i] != exp_w[i])
        begin errors++; $display("FAIL %s sample%0d got=(%0d,%0d) want=(%0d,%0d)", tag, i, got_idx[i], got_w[i], exp_idx[i], exp_w[i]); end
    end
    checks++;
    if (got_cyc.size() > 0 && got_cyc[0] - edge_cyc[1] != 4)
      begin errors++; $display("FAIL %s latency got=%0d want=4", tag, got_cyc[0] - edge_cyc[1]); end
    checks++;
    if (fv_cyc.size() != exp_fv || err_cyc.size() != exp_err)
      begin errors++; $display("FAIL %s fv_err got=%0d/%0d want=%0d/%0d", tag, fv_cyc.size(), err_cyc.size(), exp_fv, exp_err); end
    checks++;
    if (fv_cyc.size() > 0 && got_cyc.size() > 0 && fv_cyc[0] - got_cyc[got_cyc.size()-1] != FV_LAT)
      begin errors++; $display("FAIL %s fv_delay got=%0d want=%0d", tag, fv_cyc[0] - got_cyc[got_cyc.size()-1], FV_LAT); end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL %s locked got=%b want=1", tag, locked); end
  endtask

  task automatic test_ch8();
    ch8 = 1'b1;
    n_iv = 8;
    for (int i = 0; i < 7; i++) ivs[i] = 600 + 300 * i;
    ivs[7] = MAX;
    clear_logs(); model(1, 1, GAP);
    send_edges(n_iv + 1, GAP);
    ch8 = 1'b0;
    checks++;
    if (got_w.size() != exp_w.size())
      begin errors++; $display("FAIL ch8 sample_count got=%0d want=%0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_idx[i] != exp_idx[i] || got_w[i] != exp_w[i])
        begin errors++; $display("FAIL ch8 sample%0d got=(%0d,%0d) want=(%0d,%0d)", i, got_idx[i], got_w[i], exp_idx[i], exp_w[i]); end
    end
    checks++;
    if (fv_cyc.size() != exp_fv || err_cyc.size() != exp_err)
      begin errors++; $display("FAIL ch8 fv_err got=%0d/%0d want=%0d/%0d", fv_cyc.size(), err_cyc.size(), exp_fv, exp_err); end
  endtask

  task automatic test_glitch();
    n_iv = 4; ivs[0] = 1000; ivs[1] = 200; ivs[2] = 1500; ivs[3] = 1200;
    clear_logs(); model(0, 1, GAP);
    send_edges(n_iv + 1, GAP);
    checks++;
    if (got_w.size() != exp_w.size() || (got_w.size() > 0 && got_w[0] != exp_w[0]))
      begin errors++; $display("FAIL glitch samples got=%0d want=%0d", got_w.size(), exp_w.size()); end
    checks++;
    if (fv_cyc.size() != exp_fv || err_cyc.size() != exp_err)
      begin errors++; $display("FAIL glitch fv_err got=%0d/%0d want=%0d/%0d", fv_cyc.size(), err_cyc.size(), exp_fv, exp_err); end
    checks++;
    if (err_cyc.size() > 0 && got_cyc.size() > 0 && err_cyc[0] - got_cyc[0] != ivs[1])
      begin errors++; $display("FAIL glitch err_time got=%0d want=%0d", err_cyc[0] - got_cyc[0], ivs[1]); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL glitch locked got=%b want=0", locked); end
  endtask

  task automatic test_overflow();
    n_iv = 5;
    for (int i = 0; i < n_iv; i++) ivs[i] = int'($urandom_range(MIN, 1500));
    clear_logs(); model(0, 1, GAP);
    send_edges(n_iv + 1, GAP);
    checks++;
    if (got_w.size() != exp_w.size())
      begin errors++; $display("FAIL overflow sample_count got=%0d want=%0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_idx[i] != exp_idx[i] || got_w[i] != exp_w[i])
        begin errors++; $display("FAIL overflow sample%0d got=(%0d,%0d) want=(%0d,%0d)", i, got_idx[i], got_w[i], exp_idx[i], exp_w[i]); end
    end
    checks++;
    if (fv_cyc.size() != exp_fv || err_cyc.size() != exp_err)
      begin errors++; $display("FAIL overflow fv_err got=%0d/%0d want=%0d/%0d", fv_cyc.size(), err_cyc.size(), exp_fv, exp_err); end
  endtask

  task automatic test_short();
    n_iv = 2;
    for (int i = 0; i < n_iv; i++) ivs[i] = int'($urandom_range(MIN, MAX));
    clear_logs(); model(0, 1, GAP);
    send_edges(n_iv + 1, GAP);
    checks++;
    if (got_w.size() != exp_w.size() || fv_cyc.size() != exp_fv || err_cyc.size() != exp_err)
      begin errors++; $display("FAIL short counts got=%0d/%0d/%0d want=%0d/%0d/%0d", got_w.size(), fv_cyc.size(), err_cyc.size(), exp_w.size(), exp_fv, exp_err); end
    checks++;
    if (err_cyc.size() > 0 && got_cyc.size() > 1 && err_cyc[0] - got_cyc[1] != FV_LAT)
      begin errors++; $display("FAIL short err_time got=%0d want=%0d", err_cyc[0] - got_cyc[1], FV_LAT); end
    // The closing gap already counts as sync, so a good frame follows directly.
    n_iv = 4;
    for (int i = 0; i < n_iv; i++) ivs[i] = int'($urandom_range(MIN, 1500));
    clear_logs(); model(0, 1, GAP);
    send_edges(n_iv + 1, GAP);
    checks++;
    if (got_w.size() != exp_w.size())
      begin errors++; $display("FAIL after_short sample_count got=%0d want=%0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_idx[i] != exp_idx[i] || got_w[i] != exp_w[i])
        begin errors++; $display("FAIL after_short sample%0d got=(%0d,%0d) want=(%0d,%0d)", i, got_idx[i], got_w[i], exp_idx[i], exp_w[i]); end
    end
    checks++;
    if (fv_cyc.size() != exp_fv || locked !== 1'b1)
      begin errors++; $display("FAIL after_short fv_locked got=%0d/%b want=%0d/1", fv_cyc.size(), locked, exp_fv); end
  endtask

  task automatic test_inverted();
    rst_n = 1'b0; ppm_inv = 1'b1; ppm_in = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    clear_logs();
    wait_cyc(GAP);
    checks++;
    if (got_w.size() + fv_cyc.size() + err_cyc.size() != 0 || locked !== 1'b0)
      begin errors++; $display("FAIL inv_reset events=%0d locked=%b want=0/0", got_w.size() + fv_cyc.size() + err_cyc.size(), locked); end
    test_basic("inverted");
  endtask

  task automatic test_reset_mid();
    n_iv = 4; ivs[0] = 900; ivs[1] = 1100;
    clear_logs();
    send_edges(3, 700);
    checks++;
    if (locked !== 1'b1 || ch_idx !== 3'd1 || ch_width !== 12'd1100)
      begin errors++; $display("FAIL pre_reset got=%b/%0d/%0d want=1/1/1100", locked, ch_idx, ch_width); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ch_valid, ch_idx, ch_width, frame_valid, locked, err} !== 19'd0)
      begin errors++; $display("FAIL async_reset got=%b want=0", {ch_valid, ch_idx, ch_width, frame_valid, locked, err}); end
    wait_cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #960000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic("basic");
    test_ch8();
    test_glitch();
    test_overflow();
    test_short();
    test_inverted();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
